hash_nonce_scheduler: RTL and testbench
=======================================

# hash_nonce_scheduler

Sequences a bank of parallel nonce-hash engines for the Bitcoin miner. Each engine runs the second and third SHA-256 blocks for one nonce. The block:
- dispatches nonces 0..NUM_NONCES-1 to idle engines;
- captures each engine's final h0;
- shares the single memory write port among engines, writing h0 for nonce n to output_addr+n.

It sits between the top-level start/done handshake and the engine array.

## Interface
- NUM_ENG, 4: number of hash engines (1..8)
- NUM_NONCES, 16: nonces per job (1..65535)
- clk  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  job request; sampled in IDLE and DONE only
- output_addr  in  16  base write address; must be stable from start to done
- done  out  1  high while in DONE
- eng_start  out  NUM_ENG  one-cycle pulse; bit i launches engine i
- eng_nonce  out  32  nonce for the engine being launched; valid with eng_start
- eng_done  in  NUM_ENG  one-cycle pulse from engine i; eng_hash slice valid that cycle
- eng_hash  in  32*NUM_ENG  final h0 per engine; slice i is bits [32i+31:32i]
- mem_we  out  1  write strobe, one cycle per result
- mem_addr  out  16  write address
- mem_write_data  out  32  write data

## Operation
States:
- IDLE: start -> RUN. On entry to RUN: next_nonce=0, busy/pend cleared, rr=0.
- RUN: dispatch, capture and write each cycle (rules below). When next_nonce==NUM_NONCES and busy==0 -> DONE.
- DONE: done=1. start -> RUN with done<=0 and a fresh job.

Start handling:
- start in RUN is ignored.

Per-engine registers: busy[i], pend[i], nonce_of[i] (16b), res[i] (32b). Shared: next_nonce (17b), rr pointer.

Dispatch, each RUN edge:
- If next_nonce<NUM_NONCES and any busy[i]==0, pick the lowest such i.
- Set eng_start[i]<=1, eng_nonce<={16'b0,next_nonce}, nonce_of[i]<=next_nonce, busy[i]<=1, next_nonce++.
- Otherwise eng_start<=0.
- At most one launch per cycle.

Capture:
- On eng_done[i] with busy[i]=1 and pend[i]=0: res[i]<=slice i, pend[i]<=1.
- eng_done for a non-busy engine is ignored.
- A second eng_done while pend[i]=1 is ignored; the engine protocol forbids it.

Write arbitration:
- Round-robin: pick the first j with pend[j]=1, searching from rr upward and wrapping.
- Set mem_we<=1, mem_addr<=output_addr+nonce_of[j] (mod 2^16), mem_write_data<=res[j], pend[j]<=0, busy[j]<=0, rr<=(j+1) mod NUM_ENG.
- With no pending result, mem_we<=0.
- One write per cycle.

Engine reuse:
- An engine stays busy until its result is written.
- It is relaunchable at the next edge at the earliest.

Results may complete out of nonce order; addresses always follow the nonce, never the completion order.

## Timing
Reset values:
- Outputs: done=0, eng_start=0, eng_nonce=0, mem_we=0, mem_addr=0, mem_write_data=0.
- Internal: state=IDLE, busy=pend=0, rr=0, next_nonce=0.

Launch timing:
- start sampled at edge k -> RUN at k.
- eng_start[0]=1 with nonce 0 after k+1, engine 1 with nonce 1 after k+2, and so on.
- All NUM_ENG engines are launched by edge k+NUM_ENG.

Result latency:
- eng_done[i] high before edge e -> captured at e.
- mem_we high after e+1 if uncontended.
- Each additional simultaneous pending result adds one cycle.

Completion:
- After the final write edge w (busy now 0), the state reaches DONE at w+1 and done=1.
- mem_we drops at w+1.

Reset mid-job:
- All state is lost; no further writes occur.
- Engine done pulses arriving after reset are ignored.

DONE:
- mem_we=0 and eng_start=0 throughout DONE.

## Test plan
- NUM_ENG=4, NUM_NONCES=16, output_addr=16'h0100, engines each return hash=0xA5A50000+nonce 70 cycles after launch -> 16 writes, addr 0x0100+n with data 0xA5A50000+n, then done=1 one cycle after the last write.
- All four engines assert eng_done on the same cycle with rr=0 -> writes on four consecutive cycles in engine order 0,1,2,3; rr ends at 0; engines relaunch lowest-index first.
- Engine 2 finishes before engine 0 (latency 10 vs 50) -> nonce 2 is written to 0x0102 first; the address still matches the nonce.
- output_addr=16'hFFFE, NUM_NONCES=4 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
- Reset asserted during RUN after 5 launches -> outputs zero immediately; later eng_done pulses cause no mem_we; a new start restarts at nonce 0.
- Spurious eng_done[3] in IDLE, and start held high in RUN -> no capture, no write, no second job; start in DONE clears done and reruns the job.

Source files
------------

// File: rtl/hash_nonce_scheduler.sv
// Nonce dispatcher and result writer for the bank of parallel hash engines.
// Hands out nonces 0..NUM_NONCES-1 to the lowest idle engine (one launch per
// cycle), captures each engine's final h0 and funnels the results through the
// single memory write port with a round-robin arbiter. The write address
// always follows the nonce, never the completion order.
module hash_nonce_scheduler #(
  parameter int NUM_ENG    = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [15:0]            i_output_addr,
  output logic                   o_done,
  output logic [NUM_ENG-1:0]     o_eng_start,
  output logic [31:0]            o_eng_nonce,
  input  logic [NUM_ENG-1:0]     i_eng_done,
  input  logic [32*NUM_ENG-1:0]  i_eng_hash,
  output logic                   o_mem_we,
  output logic [15:0]            o_mem_addr,
  output logic [31:0]            o_mem_write_data
);

  localparam int          RRW       = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [16:0] NONCE_END = 17'(NUM_NONCES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  // Engine bookkeeping: busy from launch until its result is written,
  // pend from capture until its result is written.
  logic [NUM_ENG-1:0] r_busy;
  logic [NUM_ENG-1:0] r_pend;
  logic [NUM_ENG-1:0] w_busy_next;
  logic [NUM_ENG-1:0] w_pend_next;
  logic [15:0]        r_nonce_of [NUM_ENG];
  logic [31:0]        r_res      [NUM_ENG];
  logic [16:0]        r_next_nonce;
  logic [RRW-1:0]     r_rr;

  logic               w_job_init;
  logic               w_run;
  logic               w_have_nonce;
  logic               w_ln_found;
  logic [RRW-1:0]     w_ln_idx;
  logic [RRW-1:0]     w_ln_cand;
  logic               w_launch;
  logic               w_wr_found;
  logic [RRW-1:0]     w_wr_idx;
  logic [RRW-1:0]     w_wr_cand;
  logic [RRW-1:0]     w_rr_next;
  logic               w_write;
  logic [NUM_ENG-1:0] w_capture;

  // A job (re)starts only from IDLE or DONE; start during RUN is ignored.
  assign w_job_init   = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run        = (r_state == RUN);
  assign w_have_nonce = (r_next_nonce < NONCE_END);
  assign w_launch     = w_run && w_have_nonce && w_ln_found;
  assign w_write      = w_run && w_wr_found;
  assign w_capture    = w_run ? (i_eng_done & r_busy & ~r_pend) : '0;
  assign o_done       = (r_state == DONE);

  // Find the lowest-index idle engine; scanning downward lets the lowest win.
  always_comb begin
    w_ln_found = 1'b0;
    w_ln_idx   = '0;
    w_ln_cand  = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      w_ln_cand = RRW'(i);
      if (!r_busy[w_ln_cand]) begin
        w_ln_found = 1'b1;
        w_ln_idx   = w_ln_cand;
      end
    end
  end

  // Round-robin pick of the first pending result at or after the rr pointer.
  always_comb begin
    w_wr_found = 1'b0;
    w_wr_idx   = '0;
    w_wr_cand  = '0;
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      w_wr_cand = RRW'((int'(r_rr) + k) % NUM_ENG);
      if (r_pend[w_wr_cand]) begin
        w_wr_found = 1'b1;
        w_wr_idx   = w_wr_cand;
      end
    end
    w_rr_next = RRW'((int'(w_wr_idx) + 1) % NUM_ENG);
  end

  // Next busy/pend vectors: a launched engine becomes busy, a written engine
  // becomes free (relaunchable from the next edge), a capture marks pending.
  always_comb begin
    w_busy_next = r_busy;
    w_pend_next = r_pend;
    if (w_launch) begin
      w_busy_next[w_ln_idx] = 1'b1;
    end
    if (w_write) begin
      w_busy_next[w_wr_idx] = 1'b0;
      w_pend_next[w_wr_idx] = 1'b0;
    end
    w_pend_next = w_pend_next | w_capture;
  end

  // Job state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Job sequencing: finish once every nonce is handed out and every engine
  // has had its result written.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if ((r_next_nonce == NONCE_END) && (r_busy == '0)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (i_start) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shared bookkeeping plus launch and write-port outputs; strobes default low
  // so they are single-cycle and stay quiet outside RUN.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy           <= '0;
      r_pend           <= '0;
      r_next_nonce     <= '0;
      r_rr             <= '0;
      o_eng_start      <= '0;
      o_eng_nonce      <= '0;
      o_mem_we         <= 1'b0;
      o_mem_addr       <= '0;
      o_mem_write_data <= '0;
    end else begin
      o_eng_start <= '0;
      o_mem_we    <= 1'b0;
      if (w_job_init) begin
        r_busy       <= '0;
        r_pend       <= '0;
        r_next_nonce <= '0;
        r_rr         <= '0;
      end else if (w_run) begin
        r_busy <= w_busy_next;
        r_pend <= w_pend_next;
        if (w_launch) begin
          o_eng_start[w_ln_idx] <= 1'b1;
          o_eng_nonce           <= {16'b0, r_next_nonce[15:0]};
          r_next_nonce          <= r_next_nonce + 17'd1;
        end
        if (w_write) begin
          o_mem_we         <= 1'b1;
          o_mem_addr       <= i_output_addr + r_nonce_of[w_wr_idx];
          o_mem_write_data <= r_res[w_wr_idx];
          r_rr             <= w_rr_next;
        end
      end
    end
  end

  // Per-engine storage: the nonce handed to the engine and its captured h0.
  for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng
    // Remember which nonce engine g is working on and latch its result.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_nonce_of[g] <= '0;
        r_res[g]      <= '0;
      end else begin
        if (w_launch && (w_ln_idx == RRW'(g))) begin
          r_nonce_of[g] <= r_next_nonce[15:0];
        end
        if (w_capture[g]) begin
          r_res[g] <= i_eng_hash[32*g +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_nonce_scheduler.sv
// Bench for hash_nonce_scheduler: behavioural engines answer each launch after
// a chosen latency, every genuine result becomes an expected memory write in a
// scoreboard, and a monitor matches every DUT write against it.
module tb_hash_nonce_scheduler;

  localparam int NUM_ENG    = 4;
  localparam int NUM_NONCES = 16;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          nonce;
    int          eng;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [15:0]           outputAddr;
  logic                  done;
  logic [NUM_ENG-1:0]    engStart;
  logic [31:0]           engNonce;
  logic [NUM_ENG-1:0]    engDone;
  logic [32*NUM_ENG-1:0] engHash;
  logic                  memWe;
  logic [15:0]           memAddr;
  logic [31:0]           memWriteData;

  int errors = 0;
  int checks = 0;

  exp_t expQ[$];
  int   latMode = 0;
  int   orderMode = 0;
  int   epoch = 0;
  logic [31:0] salt = '0;
  logic [15:0] jobBase = '0;
  logic [NUM_ENG-1:0] spurMask = '0;

  bit [NUM_ENG-1:0] engActive = '0;
  int engCnt     [NUM_ENG] = '{default: 0};
  int engNonceOf [NUM_ENG] = '{default: 0};
  int engEpoch   [NUM_ENG] = '{default: 0};

  bit [NUM_ENG-1:0] tbBusy = '0;
  int nextExpNonce = 0;
  int launches = 0;
  int writes = 0;
  int weTotal = 0;
  bit lastWe = 0;
  bit lastDone = 0;

  always #5 clk = ~clk;

  hash_nonce_scheduler #(
    .NUM_ENG    (NUM_ENG),
    .NUM_NONCES (NUM_NONCES)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start          (start),
    .i_output_addr    (outputAddr),
    .o_done           (done),
    .o_eng_start      (engStart),
    .o_eng_nonce      (engNonce),
    .i_eng_done       (engDone),
    .i_eng_hash       (engHash),
    .o_mem_we         (memWe),
    .o_mem_addr       (memAddr),
    .o_mem_write_data (memWriteData)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] hashOf(input int nonce);
    return 32'hA5A50000 + 32'(nonce) + salt;
  endfunction

  function automatic int latencyFor(input int eng);
    case (latMode)
      1: return 20 - eng;
      2: begin
        case (eng)
          0: return 50;
          1: return 30;
          2: return 10;
          default: return 40;
        endcase
      end
      3: return 70;
      default: return int'($urandom_range(1, 15));
    endcase
  endfunction

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " eng_start"}, 32'(engStart), 32'd0);
    checkOutput({tag, " eng_nonce"}, engNonce, 32'd0);
    checkOutput({tag, " mem_we"}, 32'(memWe), 32'd0);
    checkOutput({tag, " mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, " mem_write_data"}, memWriteData, 32'd0);
  endtask

  task automatic jobSetup(input logic [15:0] base, input int mode, input int order);
    latMode      = mode;
    orderMode    = order;
    jobBase      = base;
    salt         = (mode == 0) ? $urandom : 32'd0;
    tbBusy       = '0;
    nextExpNonce = 0;
    launches     = 0;
    writes       = 0;
    expQ.delete();
    outputAddr   = base;
  endtask

  // Runs one complete job: start (optionally held through RUN), wait for done.
  task automatic applyStimulus(input logic [15:0] base, input int mode, input int holdCycles, input int order);
    int t;
    jobSetup(base, mode, order);
    start = 1'b1;
    waitCycle();
    checkOutput("done low once job starts", 32'(done), 32'd0);
    t = 0;
    while (!done && (t < 4000)) begin
      if (t >= holdCycles) start = 1'b0;
      waitCycle();
      t++;
    end
    start = 1'b0;
    checkOutput("job reaches done", 32'(done), 32'd1);
    checkOutput("launch count", 32'(launches), 32'(NUM_NONCES));
    checkOutput("write count", 32'(writes), 32'(NUM_NONCES));
  endtask

  // Behavioural engines: count down from launch, pulse done with h0, and
  // register the write that must eventually appear for that nonce.
  initial begin
    exp_t e;
    engDone = '0;
    engHash = '0;
    forever begin
      @(negedge clk);
      engDone = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
        if (engActive[i]) begin
          engCnt[i]--;
          if (engCnt[i] <= 0) begin
            engActive[i] = 1'b0;
            engDone[i] = 1'b1;
            engHash[i*32 +: 32] = hashOf(engNonceOf[i]);
            if (engEpoch[i] == epoch) begin
              e.addr  = 16'(int'(jobBase) + engNonceOf[i]);
              e.data  = hashOf(engNonceOf[i]);
              e.nonce = engNonceOf[i];
              e.eng   = i;
              expQ.push_back(e);
            end
          end
        end
      end
      if (spurMask != '0) begin
        for (int i = 0; i < NUM_ENG; i++) begin
          if (spurMask[i]) begin
            engDone[i] = 1'b1;
            engHash[i*32 +: 32] = 32'hDEADBEEF;
          end
        end
        spurMask = '0;
      end
      for (int i = 0; i < NUM_ENG; i++) begin
        if (engStart[i] && !reset) begin
          engActive[i] = 1'b1;
          engCnt[i] = latencyFor(i);
          engNonceOf[i] = int'(engNonce);
          engEpoch[i] = epoch;
        end
      end
    end
  end

  // Monitor: launches must go to the lowest idle engine in nonce order; every
  // write must match a pending result; done must follow the last write.
  initial begin
    int low;
    int idx;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (engStart != '0) begin
          low = -1;
          for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (!tbBusy[i]) low = i;
          end
          checkOutput("launch engine", 32'(engStart), (low < 0) ? 32'd0 : (32'd1 << low));
          checkOutput("launch nonce", engNonce, 32'(nextExpNonce));
          tbBusy = tbBusy | engStart;
          nextExpNonce++;
          launches++;
        end
        if (memWe) begin
          weTotal++;
          idx = -1;
          foreach (expQ[q]) begin
            if ((idx < 0) && (expQ[q].addr == memAddr)) idx = q;
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected write: addr=%0h data=%0h, required no write", memAddr, memWriteData);
          end else begin
            checkOutput("write data", memWriteData, expQ[idx].data);
            if (orderMode == 1) checkOutput("round-robin write order nonce", 32'(expQ[idx].nonce), 32'(writes));
            if ((orderMode == 2) && (writes == 0)) checkOutput("first write nonce", 32'(expQ[idx].nonce), 32'd2);
            tbBusy[expQ[idx].eng] = 1'b0;
            writes++;
            expQ.delete(idx);
          end
        end
        if (done && !lastDone) begin
          checkOutput("done one cycle after last write", 32'(lastWe), 32'd1);
          checkOutput("results outstanding at done", 32'(expQ.size()), 32'd0);
        end
        if (done) begin
          checkOutput("quiet in DONE", 32'({engStart, memWe}), 32'd0);
        end
        lastWe   = memWe;
        lastDone = done;
      end else begin
        lastWe   = 1'b0;
        lastDone = 1'b0;
      end
    end
  end

  initial begin
    int t;
    int we0;
    reset = 1'b1;
    start = 1'b0;
    outputAddr = '0;
    repeat (3) waitCycle();
    checkResetValues("reset");
    reset = 1'b0;
    waitCycle();
    checkOutput("idle done", 32'(done), 32'd0);

    // Spurious engine-3 completion while idle must do nothing.
    spurMask = 4'b1000;
    repeat (10) waitCycle();
    checkOutput("no write from spurious done", 32'(weTotal), 32'd0);
    checkOutput("no launch in IDLE", 32'(launches), 32'd0);

    // Fixed 70-cycle engines, start held high well into RUN.
    applyStimulus(16'h0100, 3, 50, 0);
    repeat (5) waitCycle();
    checkOutput("done held in DONE", 32'(done), 32'd1);

    // Restart from DONE: simultaneous completions, strict 0,1,2,3 order.
    applyStimulus(16'h0200, 1, 0, 1);
    // Engine 2 finishes long before engine 0.
    applyStimulus(16'h0300, 2, 0, 2);
    // Address wrap past 0xFFFF with random latencies.
    applyStimulus(16'hFFF8, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(16'($urandom), 0, int'($urandom_range(0, 5)), 0);
    end

    // Reset in the middle of a job, after the fifth launch.
    jobSetup(16'h0400, 3, 0);
    start = 1'b1;
    waitCycle();
    start = 1'b0;
    t = 0;
    while ((launches < 5) && (t < 1000)) begin
      waitCycle();
      t++;
    end
    checkOutput("fifth launch reached", 32'(launches), 32'd5);
    #1;
    reset = 1'b1;
    epoch++;
    expQ.delete();
    tbBusy = '0;
    #1;
    checkResetValues("mid-job reset");
    waitCycle();
    reset = 1'b0;
    we0 = weTotal;
    repeat (100) waitCycle();
    checkOutput("no write after reset", 32'(weTotal - we0), 32'd0);
    checkOutput("idle after reset", 32'(done), 32'd0);
    applyStimulus(16'h0500, 0, 0, 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
